serial_add_sequencer: RTL



---
 rtl/serial_add_sequencer.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/serial_add_sequencer.sv
// serial_add_sequencer: bit-serial adder controller. A single full_adder cell
// is stepped across a WIDTH-bit addition, LSB first, one bit per clock.
//
// Ports
//   clk        system clock, rising edge
//   rst        synchronous active-high reset
//   in_valid   operands a/b/cin valid          in_ready  can accept operands
//   a, b       WIDTH-bit operands               cin       carry into bit 0
//   out_valid  result valid, held until taken   out_ready consumer accepts result
//   sum        low WIDTH bits of a+b+cin        cout      carry out of MSB
//   ovf        two's-complement overflow        busy      high while adding
//
// WIDTH legal range is 2..64.

// One-bit full adder cell; the only arithmetic in this block.
module full_adder (
  input  logic i_a,
  input  logic i_b,
  input  logic i_cin,
  output logic o_sum,
  output logic o_cout
);
  assign o_sum  = i_a ^ i_b ^ i_cin;
  assign o_cout = (i_a & i_b) | (i_cin & (i_a ^ i_b));
endmodule

module serial_add_sequencer #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             busy
);

  localparam int unsigned CNT_W = $clog2(WIDTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;

  logic [WIDTH-1:0]   r_a_sh;
  logic [WIDTH-1:0]   r_b_sh;
  logic [WIDTH-1:0]   r_sum_sh;
  logic               r_carry_q;
  logic [CNT_W-1:0]   r_cnt;

  logic               r_in_ready;
  logic               r_out_valid;
  logic               r_busy;
  logic [WIDTH-1:0]   r_sum;
  logic               r_cout;
  logic               r_ovf;

  logic               w_fa_sum;
  logic               w_fa_cout;
  logic               w_accept;
  logic               w_last;
  logic [WIDTH-1:0]   w_sum_nxt;

  // Single time-multiplexed adder cell fed from the operand LSBs and carry flop.
  full_adder u_fa (
    .i_a    (r_a_sh[0]),
    .i_b    (r_b_sh[0]),
    .i_cin  (r_carry_q),
    .o_sum  (w_fa_sum),
    .o_cout (w_fa_cout)
  );

  // in_ready is only ever high in IDLE, so this is the accepting edge.
  assign w_accept  = (r_state == S_IDLE) && in_valid;
  assign w_last    = (r_state == S_RUN) && (r_cnt == CNT_W'(WIDTH - 1));
  // Sum bits enter at the MSB; after WIDTH shifts bit 0 lands at position 0.
  assign w_sum_nxt = {w_fa_sum, r_sum_sh[WIDTH-1:1]};

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (in_valid)  w_state_nxt = S_RUN;
      S_RUN:  if (w_last)    w_state_nxt = S_DONE;
      S_DONE: if (out_ready) w_state_nxt = S_IDLE;
      default:               w_state_nxt = S_IDLE;
    endcase
  end

  // Handshake/status flags registered from the next state so they line up with it.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_in_ready  <= (w_state_nxt == S_IDLE);
      r_out_valid <= (w_state_nxt == S_DONE);
      r_busy      <= (w_state_nxt == S_RUN);
    end
  end

  // Operand/carry/sum shifting and result capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_a_sh    <= '0;
      r_b_sh    <= '0;
      r_sum_sh  <= '0;
      r_carry_q <= 1'b0;
      r_cnt     <= '0;
      r_sum     <= '0;
      r_cout    <= 1'b0;
      r_ovf     <= 1'b0;
    end else if (w_accept) begin
      r_a_sh    <= a;
      r_b_sh    <= b;
      r_carry_q <= cin;
      r_cnt     <= '0;
    end else if (r_state == S_RUN) begin
      r_a_sh    <= {1'b0, r_a_sh[WIDTH-1:1]};
      r_b_sh    <= {1'b0, r_b_sh[WIDTH-1:1]};
      r_sum_sh  <= w_sum_nxt;
      r_carry_q <= w_fa_cout;
      r_cnt     <= r_cnt + CNT_W'(1);
      if (w_last) begin
        r_sum  <= w_sum_nxt;
        r_cout <= w_fa_cout;
        // Carry into the MSB differs from carry out of it on signed overflow.
        r_ovf  <= r_carry_q ^ w_fa_cout;
      end
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign busy      = r_busy;
  assign sum       = r_sum;
  assign cout      = r_cout;
  assign ovf       = r_ovf;

endmodule
